// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues latency-1 reads to instruction memory
// and buffers returned words in a 2-entry prefetch queue feeding the core.
// state | meaning
// BOOT  | first cycle after reset release, no requests issued
// RUN   | fetching under the credit rule
module instr_fetch_unit #(
   parameter int                ADDR_W   = 14,
   parameter int                DATA_W   = 19,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instruction,
   output logic [ADDR_W-1:0] instr_pc
);

   typedef enum logic {ST_BOOT, ST_RUN} state_t;

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_infl_pc;
   logic              r_inflight;
   logic [1:0]        r_count;
   logic [DATA_W-1:0] r_q_dat0, r_q_dat1;
   logic [ADDR_W-1:0] r_q_pc0,  r_q_pc1;

   logic              w_pop;
   logic              w_req;
   logic [2:0]        w_credit;
   logic [1:0]        w_nxt_count;
   logic [DATA_W-1:0] w_nxt_dat0, w_nxt_dat1;
   logic [ADDR_W-1:0] w_nxt_pc0,  w_nxt_pc1;

   assign w_pop    = instr_valid & instr_ready;
   assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_req    = (r_state == ST_RUN) & ~halt & ~redirect & (w_credit < 3'd2);

   assign imem_req    = w_req;
   assign imem_addr   = r_pc;
   assign instr_valid = (r_count != 2'd0);
   assign instruction = r_q_dat0;
   assign instr_pc    = r_q_pc0;

   // Slots at or beyond the occupancy are kept at zero, so a pop shifts zeros into the head.
   always_comb begin
      w_nxt_count = r_count;
      w_nxt_dat0  = r_q_dat0;
      w_nxt_dat1  = r_q_dat1;
      w_nxt_pc0   = r_q_pc0;
      w_nxt_pc1   = r_q_pc1;
      if (w_pop) begin
         w_nxt_dat0  = r_q_dat1;
         w_nxt_pc0   = r_q_pc1;
         w_nxt_dat1  = '0;
         w_nxt_pc1   = '0;
         w_nxt_count = r_count - 2'd1;
      end
      if (r_inflight) begin
         if (w_nxt_count == 2'd0) begin
            w_nxt_dat0 = imem_rdata;
            w_nxt_pc0  = r_infl_pc;
         end else begin
            w_nxt_dat1 = imem_rdata;
            w_nxt_pc1  = r_infl_pc;
         end
         w_nxt_count = w_nxt_count + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_BOOT;
         r_pc       <= RESET_PC;
         r_infl_pc  <= RESET_PC;
         r_inflight <= 1'b0;
         r_count    <= 2'd0;
         r_q_dat0   <= '0;
         r_q_dat1   <= '0;
         r_q_pc0    <= '0;
         r_q_pc1    <= '0;
      end else begin
         if (r_state == ST_BOOT)
            r_state <= ST_RUN;
         if (redirect) begin
            // Flush everything, including a response returning this cycle.
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_q_dat0   <= '0;
            r_q_dat1   <= '0;
            r_q_pc0    <= '0;
            r_q_pc1    <= '0;
         end else begin
            r_count    <= w_nxt_count;
            r_q_dat0   <= w_nxt_dat0;
            r_q_dat1   <= w_nxt_dat1;
            r_q_pc0    <= w_nxt_pc0;
            r_q_pc1    <= w_nxt_pc1;
            r_inflight <= w_req;
            if (w_req) begin
               r_pc      <= r_pc + PC_ONE;
               r_infl_pc <= r_pc;
            end
         end
      end
   end

endmodule
